// File: rtl/button_event_pkg.sv
// Shared event codes and per-button FSM state encoding for the button event unit.
package button_event_pkg;

   localparam logic [1:0] EVT_PRESS   = 2'd0;
   localparam logic [1:0] EVT_LONG    = 2'd1;
   localparam logic [1:0] EVT_REPEAT  = 2'd2;
   localparam logic [1:0] EVT_RELEASE = 2'd3;

   typedef enum logic [1:0] {
      BTN_IDLE    = 2'd0,
      BTN_PRESSED = 2'd1,
      BTN_HELD    = 2'd2
   } btn_fsm_e;

endpackage

// File: rtl/button_hold_fsm.sv
// One button: hold-timing FSM with its counter and the one-entry pending event slot.
module button_hold_fsm
   import button_event_pkg::*;
#(
   parameter int LONG_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int CNT_W      = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       drain,
   output logic       pend_valid,
   output logic [1:0] pend_kind,
   output logic       ovf_set
);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

   btn_fsm_e         state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             gen_s;
   logic [1:0]       gen_kind_s;

   // Next state / event generation; release is checked first so it beats LONG and REPEAT
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      gen_s      = 1'b0;
      gen_kind_s = EVT_PRESS;
      case (state_r)
         BTN_IDLE: begin
            if (btn) begin
               state_s    = BTN_PRESSED;
               cnt_s      = '0;
               gen_s      = 1'b1;
               gen_kind_s = EVT_PRESS;
            end else begin
               cnt_s = cnt_r;
            end
         end
         BTN_PRESSED: begin
            if (!btn) begin
               state_s    = BTN_IDLE;
               gen_s      = 1'b1;
               gen_kind_s = EVT_RELEASE;
            end else if (cnt_r == LONG_LAST) begin
               state_s    = BTN_HELD;
               cnt_s      = '0;
               gen_s      = 1'b1;
               gen_kind_s = EVT_LONG;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         BTN_HELD: begin
            if (!btn) begin
               state_s    = BTN_IDLE;
               gen_s      = 1'b1;
               gen_kind_s = EVT_RELEASE;
            end else if ((REPEAT_CYC != 0) && (cnt_r == REPEAT_LAST)) begin
               cnt_s      = '0;
               gen_s      = 1'b1;
               gen_kind_s = EVT_REPEAT;
            end else if (REPEAT_CYC != 0) begin
               cnt_s = cnt_r + CNT_W'(1);
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = BTN_IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // FSM state and hold counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= BTN_IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Pending slot: a drain in the same cycle frees room for the new event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_kind  <= EVT_PRESS;
      end else if (gen_s && (!pend_valid || drain)) begin
         pend_valid <= 1'b1;
         pend_kind  <= gen_kind_s;
      end else if (drain) begin
         pend_valid <= 1'b0;
      end else begin
         pend_valid <= pend_valid;
      end
   end

   assign ovf_set = gen_s && pend_valid && !drain;

endmodule

// File: rtl/button_event_unit.sv
// Per-button event generators drained by a lowest-index-first arbiter onto one valid/ready stream.
module button_event_unit
   import button_event_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int LONG_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   localparam int BTN_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_state,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [BTN_W-1:0] evt_btn,
   output logic [1:0]       evt_kind,
   output logic [N_BTN-1:0] ovf,
   input  logic             ovf_clr
);

   localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
   localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

   logic [N_BTN-1:0]      pend_valid_s;
   logic [N_BTN-1:0][1:0] pend_kind_s;
   logic [N_BTN-1:0]      ovf_set_s;
   logic [N_BTN-1:0]      drain_s;
   logic                  load_s;
   logic                  any_s;
   logic [BTN_W-1:0]      sel_s;

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      button_hold_fsm #(
         .LONG_CYC   (LONG_CYC),
         .REPEAT_CYC (REPEAT_CYC),
         .CNT_W      (CNT_W)
      ) u_fsm (
         .clk        (clk),
         .rst_n      (rst_n),
         .btn        (btn_state[g]),
         .drain      (drain_s[g]),
         .pend_valid (pend_valid_s[g]),
         .pend_kind  (pend_kind_s[g]),
         .ovf_set    (ovf_set_s[g])
      );
   end

   // Fixed-priority pick: scan downwards so the lowest occupied index is the one left in sel_s
   always_comb begin
      any_s  = 1'b0;
      sel_s  = '0;
      load_s = !evt_valid || evt_ready;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pend_valid_s[i]) begin
            any_s = 1'b1;
            sel_s = BTN_W'(i);
         end else begin
            any_s = any_s;
         end
      end
      if (load_s) begin
         drain_s = pend_valid_s & (~pend_valid_s + N_BTN'(1));
      end else begin
         drain_s = '0;
      end
   end

   // Output register; payload holds steady while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_btn   <= '0;
         evt_kind  <= EVT_PRESS;
      end else if (load_s) begin
         evt_valid <= any_s;
         if (any_s) begin
            evt_btn  <= sel_s;
            evt_kind <= pend_kind_s[sel_s];
         end else begin
            evt_btn  <= evt_btn;
         end
      end else begin
         evt_valid <= evt_valid;
      end
   end

   // Sticky drop flags; a fresh drop outranks a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= '0;
      end else begin
         ovf <= (ovf & ~{N_BTN{ovf_clr}}) | ovf_set_s;
      end
   end

endmodule

// File: tb/tb_button_event_unit.sv
// Scoreboard bench: a duration-based event model predicts the serialized stream, a monitor checks it.
module tb_button_event_unit;
   import button_event_pkg::*;

   localparam int N = 4;
   localparam int L = 8;
   localparam int R = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn_state = '0;
   logic         evt_valid;
   logic         evt_ready = 1'b1;
   logic [1:0]   evt_btn;
   logic [1:0]   evt_kind;
   logic [N-1:0] ovf;
   logic         ovf_clr = 1'b0;

   always #5 clk = ~clk;

   button_event_unit #(.N_BTN(N), .LONG_CYC(L), .REPEAT_CYC(R)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_state (btn_state),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_btn   (evt_btn),
      .evt_kind  (evt_kind),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   typedef struct {int cyc; int btn; int kind;} exp_t;
   exp_t q[$];

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   bit           m_valid;
   bit           slot_v[N];
   int           slot_k[N];
   bit           prev[N];
   int           held[N];
   bit [N-1:0]   m_ovf;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: events come from how long each button has been held, not from a counter FSM
   initial begin
      int f;
      int ev;
      bit [N-1:0] set;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_valid = 1'b0;
            m_ovf = '0;
            for (int b = 0; b < N; b++) begin
               slot_v[b] = 1'b0; slot_k[b] = 0; prev[b] = 1'b0; held[b] = 0;
            end
            q.delete();
         end else begin
            cyc++;
            if (!m_valid || evt_ready) begin
               f = -1;
               for (int b = N - 1; b >= 0; b--) if (slot_v[b]) f = b;
               if (f >= 0) begin
                  m_valid = 1'b1;
                  slot_v[f] = 1'b0;
                  q.push_back('{cyc, f, slot_k[f]});
               end else begin
                  m_valid = 1'b0;
               end
            end
            set = '0;
            for (int b = 0; b < N; b++) begin
               ev = -1;
               if (btn_state[b] && !prev[b]) begin
                  ev = 0; held[b] = 0;
               end else if (!btn_state[b] && prev[b]) begin
                  ev = 3;
               end else if (btn_state[b]) begin
                  held[b]++;
                  if (held[b] == L) ev = 1;
                  else if (held[b] > L && ((held[b] - L) % R) == 0) ev = 2;
               end
               prev[b] = btn_state[b];
               if (ev >= 0) begin
                  if (slot_v[b]) set[b] = 1'b1;
                  else begin slot_v[b] = 1'b1; slot_k[b] = ev; end
               end
            end
            m_ovf = (ovf_clr ? '0 : m_ovf) | set;
         end
      end
   end

   // Monitor: pops the expected queue on every handshake and checks payload and first-present cycle
   initial begin
      bit presenting;
      int pres_cyc;
      exp_t e;
      presenting = 1'b0;
      pres_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            presenting = 1'b0;
         end else begin
            check("evt_valid", int'(evt_valid), int'(m_valid));
            check("ovf", int'(ovf), int'(m_ovf));
            if (evt_valid && !presenting) begin
               presenting = 1'b1;
               pres_cyc = cyc;
            end
            if (evt_valid && evt_ready) begin
               presenting = 1'b0;
               if (q.size() == 0) begin
                  check("unexpected_event", 1, 0);
               end else begin
                  e = q.pop_front();
                  check("evt_btn", int'(evt_btn), e.btn);
                  check("evt_kind", int'(evt_kind), e.kind);
                  check("evt_time", pres_cyc, e.cyc);
               end
            end
         end
      end
   end

   task automatic idle(int n);
      btn_state = '0;
      evt_ready = 1'b1;
      ovf_clr = 1'b0;
      repeat (n) step();
   endtask

   task automatic random_phase(int n, int flip_div);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, flip_div - 1) == 0) btn_state[b] = ~btn_state[b];
         evt_ready = ($urandom_range(0, 3) != 0);
         ovf_clr = ($urandom_range(0, 29) == 0);
         step();
      end
   endtask

   initial begin
      #12;
      check("reset_valid", int'(evt_valid), 0);
      check("reset_btn", int'(evt_btn), 0);
      check("reset_kind", int'(evt_kind), 0);
      check("reset_ovf", int'(ovf), 0);
      step();
      rst_n = 1'b1;
      idle(3);

      // short tap, long hold, simultaneous press, release colliding with LONG
      btn_state[0] = 1'b1; repeat (3) step(); idle(10);
      btn_state[2] = 1'b1; repeat (20) step(); idle(10);
      btn_state[1] = 1'b1; btn_state[3] = 1'b1; repeat (3) step(); idle(10);
      btn_state[0] = 1'b1; repeat (8) step(); idle(10);

      // backpressure: second tap is lost behind the stalled PRESS and pending RELEASE
      evt_ready = 1'b0;
      btn_state[0] = 1'b1; repeat (2) step();
      btn_state[0] = 1'b0; repeat (2) step();
      btn_state[0] = 1'b1; repeat (2) step();
      btn_state[0] = 1'b0; repeat (2) step();
      check("bp_valid", int'(evt_valid), 1);
      check("bp_kind", int'(evt_kind), int'(EVT_PRESS));
      check("bp_ovf", int'(ovf), 1);
      evt_ready = 1'b1;
      repeat (4) step();
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      check("ovf_cleared", int'(ovf), 0);
      idle(5);

      random_phase(2000, 10);
      random_phase(1500, 30);
      idle(40);

      // reset while btn2 is in HELD with a stalled output and a dropped REPEAT
      evt_ready = 1'b0;
      btn_state[2] = 1'b1;
      repeat (15) step();
      check("prehold_valid", int'(evt_valid), 1);
      check("prehold_btn", int'(evt_btn), 2);
      check("prehold_ovf", int'(ovf), 4);
      rst_n = 1'b0;
      #1;
      check("async_valid", int'(evt_valid), 0);
      check("async_btn", int'(evt_btn), 0);
      check("async_kind", int'(evt_kind), 0);
      check("async_ovf", int'(ovf), 0);
      repeat (2) step();
      rst_n = 1'b1;
      evt_ready = 1'b1;
      repeat (2) step();
      check("post_reset_valid", int'(evt_valid), 1);
      check("post_reset_btn", int'(evt_btn), 2);
      check("post_reset_kind", int'(evt_kind), int'(EVT_PRESS));
      idle(10);

      random_phase(1000, 12);
      idle(40);
      check("queue_drained", q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
